// File: rtl/mem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_pkg : shared FSM state type and default constants for the        |
// |           external byte-memory bridge.          Rev 1.0              |
// +----------------------------------------------------------------------+
package mem_pkg;

  localparam int c_DATA_W_DEF   = 32;
  localparam int c_MEM_AW_DEF   = 16;
  localparam int c_WAIT_CYC_DEF = 2;
  localparam int c_WAIT_W       = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    TURN   = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/ext_mem_bridge_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ext_mem_bridge_if : core-side request/response bus of the bridge.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface ext_mem_bridge_if
  import mem_pkg::*;
#(
  parameter int DATA_W = c_DATA_W_DEF
) ();

  localparam int BYTES = DATA_W / 8;

  logic              req;
  logic              we;
  logic [31:0]       a;
  logic [DATA_W-1:0] wd;
  logic [BYTES-1:0]  be;
  logic              ready;
  logic              done;
  logic [DATA_W-1:0] rd;

  modport master (
    output req, we, a, wd, be,
    input  ready, done, rd
  );

  modport slave (
    input  req, we, a, wd, be,
    output ready, done, rd
  );

endinterface
`default_nettype wire

// File: rtl/ext_mem_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ext_mem_bridge : splits core word accesses into byte-serial strobed  |
// |                  cycles on an 8-bit asynchronous memory.  Rev 1.0    |
// +----------------------------------------------------------------------+
module ext_mem_bridge
  import mem_pkg::*;
#(
  parameter int DATA_W   = c_DATA_W_DEF,
  parameter int MEM_AW   = c_MEM_AW_DEF,
  parameter int WAIT_CYC = c_WAIT_CYC_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  ext_mem_bridge_if.slave   bus,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              mem_ce_n,
  output logic              mem_oe_n,
  output logic              mem_we_n
);

  localparam int BYTES  = DATA_W / 8;
  localparam int LANE_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(WAIT_CYC - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_we;
  logic [MEM_AW-1:0]   r_base;
  logic [DATA_W-1:0]   r_wd;
  logic [BYTES-1:0]    r_be;
  logic [LANE_W-1:0]   r_lane;
  logic [LANE_W-1:0]   w_lane_nxt;
  logic [c_WAIT_W-1:0] r_wait;
  logic [DATA_W-1:0]   r_rd;
  logic                r_ce_n;
  logic                r_oe_n;
  logic                r_we_n;
  logic [MEM_AW-1:0]   r_addr;
  logic [7:0]          r_wdata;

  logic                w_idle;
  logic                w_accept;
  logic                w_wait_last;
  logic                w_we_sel;
  logic [MEM_AW-1:0]   w_base;
  logic [MEM_AW-1:0]   w_base_sel;
  logic [DATA_W-1:0]   w_wd_sel;
  logic [BYTES-1:0]    w_cand;
  logic                w_found;
  logic [LANE_W-1:0]   w_first;
  logic                w_ce_n_nxt;
  logic                w_oe_n_nxt;
  logic                w_we_n_nxt;
  logic [31:0]         w_unused_a;

  // Address bits above MEM_AW and below word alignment are intentionally dropped.
  assign w_unused_a  = bus.a;
  assign w_base      = bus.a[MEM_AW-1:0] & ~MEM_AW'(BYTES - 1);
  assign w_idle      = (r_state == IDLE);
  assign w_accept    = w_idle && bus.req;
  assign w_wait_last = (r_wait == c_WAIT_LAST);
  assign w_we_sel    = w_idle ? bus.we : r_we;
  assign w_base_sel  = w_idle ? w_base : r_base;
  assign w_wd_sel    = w_idle ? bus.wd : r_wd;

  // Lowest lane still to be serviced: from IDLE any enabled lane, otherwise above the current one.
  always_comb begin
    w_cand  = '0;
    w_first = '0;
    for (int k = 0; k < BYTES; k++) begin
      if (w_idle)
        w_cand[k] = bus.we ? bus.be[k] : 1'b1;
      else
        w_cand[k] = r_be[k] && (k > int'(r_lane));
    end
    for (int k = BYTES - 1; k >= 0; k--) begin
      if (w_cand[k])
        w_first = LANE_W'(k);
    end
    w_found = |w_cand;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_lane_nxt  = r_lane;
    w_ce_n_nxt  = 1'b1;
    w_oe_n_nxt  = 1'b1;
    w_we_n_nxt  = 1'b1;
    case (r_state)
      IDLE: begin
        if (bus.req) begin
          if (w_found) begin
            w_state_nxt = ACCESS;
            w_lane_nxt  = w_first;
          end else begin
            w_state_nxt = DONE;
          end
        end
      end
      ACCESS: begin
        if (w_wait_last)
          w_state_nxt = TURN;
      end
      TURN: begin
        if (w_found) begin
          w_state_nxt = ACCESS;
          w_lane_nxt  = w_first;
        end else begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
    endcase
    // Strobes are decoded from the next state so the registered pins line up with ACCESS.
    if (w_state_nxt == ACCESS) begin
      w_ce_n_nxt = 1'b0;
      w_oe_n_nxt = w_we_sel;
      w_we_n_nxt = !w_we_sel;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_state <= IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_we    <= 1'b0;
      r_base  <= '0;
      r_wd    <= '0;
      r_be    <= '0;
      r_lane  <= '0;
      r_wait  <= '0;
      r_rd    <= '0;
      r_ce_n  <= 1'b1;
      r_oe_n  <= 1'b1;
      r_we_n  <= 1'b1;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_lane <= w_lane_nxt;
      r_ce_n <= w_ce_n_nxt;
      r_oe_n <= w_oe_n_nxt;
      r_we_n <= w_we_n_nxt;
      if (w_accept) begin
        r_we   <= bus.we;
        r_base <= w_base;
        r_wd   <= bus.wd;
        r_be   <= bus.we ? bus.be : '1;
      end
      if (r_state == ACCESS)
        r_wait <= w_wait_last ? '0 : r_wait + c_WAIT_W'(1);
      else
        r_wait <= '0;
      if ((r_state == ACCESS) && w_wait_last && !r_we)
        r_rd[8*int'(r_lane) +: 8] <= mem_rdata;
      if (w_state_nxt == ACCESS) begin
        r_addr  <= w_base_sel + MEM_AW'(w_lane_nxt);
        r_wdata <= w_wd_sel[8*int'(w_lane_nxt) +: 8];
      end
    end
  end

  assign bus.ready = w_idle;
  assign bus.done  = (r_state == DONE);
  assign bus.rd    = r_rd;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign mem_ce_n  = r_ce_n;
  assign mem_oe_n  = r_oe_n;
  assign mem_we_n  = r_we_n;

endmodule
`default_nettype wire

// File: tb/tb_ext_mem_bridge.sv
`default_nettype none
// Testbench for ext_mem_bridge: 32-bit/2-wait instance driven from a vector
// table plus reset/back-to-back sequences, and a 16-bit/1-wait instance.
module tb_ext_mem_bridge;
  import mem_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  ext_mem_bridge_if #(.DATA_W(32)) bus1 ();
  ext_mem_bridge_if #(.DATA_W(16)) bus2 ();

  logic [15:0] m1_addr, m2_addr;
  logic [7:0]  m1_wdata, m1_rdata, m2_wdata, m2_rdata;
  logic        m1_ce_n, m1_oe_n, m1_we_n, m2_ce_n, m2_oe_n, m2_we_n;

  ext_mem_bridge #(.DATA_W(32), .MEM_AW(16), .WAIT_CYC(2)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(bus1),
    .mem_addr(m1_addr), .mem_wdata(m1_wdata), .mem_rdata(m1_rdata),
    .mem_ce_n(m1_ce_n), .mem_oe_n(m1_oe_n), .mem_we_n(m1_we_n)
  );

  ext_mem_bridge #(.DATA_W(16), .MEM_AW(16), .WAIT_CYC(1)) dut2 (
    .clk(clk), .reset_n(reset_n), .bus(bus2),
    .mem_addr(m2_addr), .mem_wdata(m2_wdata), .mem_rdata(m2_rdata),
    .mem_ce_n(m2_ce_n), .mem_oe_n(m2_oe_n), .mem_we_n(m2_we_n)
  );

  // Memory models: initial contents come from a function, writes land in an overlay.
  function automatic logic [7:0] pre1(input logic [15:0] ad);
    case (ad)
      16'h0100: return 8'h11;
      16'h0101: return 8'h22;
      16'h0102: return 8'h33;
      16'h0103: return 8'h44;
      default:  return ad[7:0] ^ 8'h5A;
    endcase
  endfunction

  function automatic logic [7:0] pre2(input logic [15:0] ad);
    case (ad)
      16'h0010: return 8'hA5;
      16'h0011: return 8'h3C;
      default:  return ad[7:0] ^ 8'h5A;
    endcase
  endfunction

  logic [7:0] mem1 [0:65535];
  bit         wr1  [0:65535];
  logic [7:0] ref_mem [0:65535];
  bit         ref_wr  [0:65535];

  function automatic logic [7:0] mem1_byte(input logic [15:0] ad);
    return wr1[ad] ? mem1[ad] : pre1(ad);
  endfunction

  function automatic logic [7:0] ref_byte(input logic [15:0] ad);
    return ref_wr[ad] ? ref_mem[ad] : pre1(ad);
  endfunction

  always @(posedge clk) begin
    if (!m1_ce_n && !m1_we_n) begin
      mem1[m1_addr] <= m1_wdata;
      wr1[m1_addr]  <= 1'b1;
    end
  end

  assign m1_rdata = (!m1_ce_n && !m1_oe_n) ? mem1_byte(m1_addr) : 8'hEE;
  assign m2_rdata = (!m2_ce_n && !m2_oe_n) ? pre2(m2_addr) : 8'hEE;

  int strobe_bad = 0;
  always @(negedge clk) begin
    if ((!m1_oe_n && !m1_we_n) || (!m2_oe_n && !m2_we_n))
      strobe_bad++;
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic run1(input logic w, input logic [31:0] ad, input logic [31:0] d,
                      input logic [3:0] b, output int lat, output int stb);
    bit got;
    got = 1'b0;
    lat = -1;
    stb = 0;
    @(negedge clk);
    bus1.req = 1'b1; bus1.we = w; bus1.a = ad; bus1.wd = d; bus1.be = b;
    @(posedge clk);
    #1 bus1.req = 1'b0;
    for (int i = 1; i <= 100 && !got; i++) begin
      @(negedge clk);
      if (!m1_ce_n) stb++;
      if (bus1.done) begin
        got = 1'b1;
        lat = i;
      end
    end
  endtask

  typedef struct {
    logic        we;
    logic [31:0] a;
    logic [31:0] wd;
    logic [3:0]  be;
    logic [31:0] exp_rd;
    int          exp_lat;
    int          exp_stb;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int lat, stb, first_done, second_done, ready_cnt;
    bit extra;
    logic [15:0] ad;
    logic [7:0]  eb;

    vecs[0] = '{1'b0, 32'h0000_0100, 32'h0,         4'b0000, 32'h4433_2211, 13, 8};
    vecs[1] = '{1'b1, 32'h0000_0200, 32'hAABB_CCDD, 4'b0101, 32'h4433_2211,  7, 4};
    vecs[2] = '{1'b1, 32'h0000_0300, 32'h1234_5678, 4'b0000, 32'h4433_2211,  1, 0};
    vecs[3] = '{1'b1, 32'h0000_0103, 32'h0102_0304, 4'b1111, 32'h4433_2211, 13, 8};
    vecs[4] = '{1'b0, 32'h0000_0102, 32'h0,         4'b1111, 32'h0102_0304, 13, 8};
    vecs[5] = '{1'b1, 32'h0000_0204, 32'h9988_7766, 4'b1000, 32'h0102_0304,  4, 2};
    vecs[6] = '{1'b0, 32'h0001_0206, 32'h0,         4'b0000, 32'h995C_5F5E, 13, 8};

    bus1.req = 1'b0; bus1.we = 1'b0; bus1.a = '0; bus1.wd = '0; bus1.be = '0;
    bus2.req = 1'b0; bus2.we = 1'b0; bus2.a = '0; bus2.wd = '0; bus2.be = '0;

    repeat (3) @(negedge clk);
    check("reset_ready", {31'b0, bus1.ready}, 32'd1);
    check("reset_done",  {31'b0, bus1.done},  32'd0);
    check("reset_rd",    bus1.rd, 32'h0);
    check("reset_strb",  {29'b0, m1_ce_n, m1_oe_n, m1_we_n}, 32'h7);
    check("reset_addr",  {16'b0, m1_addr}, 32'h0);
    reset_n = 1'b1;

    for (int v = 0; v < 7; v++) begin
      run1(vecs[v].we, vecs[v].a, vecs[v].wd, vecs[v].be, lat, stb);
      check($sformatf("v%0d_latency", v), lat, vecs[v].exp_lat);
      check($sformatf("v%0d_strobes", v), stb, vecs[v].exp_stb);
      check($sformatf("v%0d_rd", v), bus1.rd, vecs[v].exp_rd);
      @(negedge clk);
      check($sformatf("v%0d_done_pulse", v), {31'b0, bus1.done}, 32'd0);
      check($sformatf("v%0d_ready", v), {31'b0, bus1.ready}, 32'd1);
      if (vecs[v].we) begin
        for (int k = 0; k < 4; k++) begin
          ad = (vecs[v].a[15:0] & 16'hFFFC) + 16'(k);
          eb = vecs[v].be[k] ? vecs[v].wd[8*k +: 8] : ref_byte(ad);
          check($sformatf("v%0d_mem_lane%0d", v, k), {24'b0, mem1_byte(ad)}, {24'b0, eb});
          ref_mem[ad] = eb;
          ref_wr[ad]  = 1'b1;
        end
      end
    end

    // Reset asserted in the middle of lane 2 of a read.
    @(negedge clk);
    bus1.req = 1'b1; bus1.we = 1'b0; bus1.a = 32'h0100; bus1.be = '0;
    @(posedge clk);
    #1 bus1.req = 1'b0;
    repeat (7) @(negedge clk);
    check("rst_mid_ce", {31'b0, m1_ce_n}, 32'd0);
    check("rst_mid_addr", {16'b0, m1_addr}, 32'h0102);
    reset_n = 1'b0;
    #1;
    check("rst_mid_strb", {29'b0, m1_ce_n, m1_oe_n, m1_we_n}, 32'h7);
    check("rst_mid_ready", {31'b0, bus1.ready}, 32'd1);
    check("rst_mid_rd", bus1.rd, 32'h0);
    check("rst_mid_addr0", {16'b0, m1_addr}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    extra = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (bus1.done || !m1_ce_n || !bus1.ready) extra = 1'b1;
    end
    check("rst_no_resume", {31'b0, extra}, 32'd0);

    // req held high: two reads separated by one IDLE cycle, nothing queued.
    first_done = 0; second_done = 0; ready_cnt = 0;
    @(negedge clk);
    bus1.req = 1'b1; bus1.we = 1'b0; bus1.a = 32'h0100;
    for (int i = 1; i <= 60 && second_done == 0; i++) begin
      @(negedge clk);
      if (bus1.ready && first_done != 0) ready_cnt++;
      if (bus1.done) begin
        if (first_done == 0) first_done = i;
        else begin
          second_done = i;
          bus1.req = 1'b0;
        end
      end
    end
    bus1.req = 1'b0;
    check("b2b_first_done", first_done, 32'd13);
    check("b2b_second_done", second_done, 32'd27);
    check("b2b_idle_gap", ready_cnt, 32'd1);
    check("b2b_rd", bus1.rd, 32'h0102_0304);
    extra = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (bus1.done || !m1_ce_n) extra = 1'b1;
    end
    check("b2b_no_queue", {31'b0, extra}, 32'd0);

    // 16-bit, single wait-state instance.
    @(negedge clk);
    bus2.req = 1'b1; bus2.we = 1'b0; bus2.a = 32'h0011;
    @(posedge clk);
    #1 bus2.req = 1'b0;
    lat = -1; stb = 0;
    for (int i = 1; i <= 50 && lat < 0; i++) begin
      @(negedge clk);
      if (!m2_ce_n) stb++;
      if (bus2.done) lat = i;
    end
    check("w16_latency", lat, 32'd5);
    check("w16_strobes", stb, 32'd2);
    check("w16_rd", {16'b0, bus2.rd}, 32'h0000_3CA5);

    check("oe_we_exclusive", strobe_bad, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
